// File: rtl/chess_clock_core.sv
// Two-player chess clock: per-player min:sec countdown driven by a one-second tick,
// turn handover on player presses, optional Fischer increment, sticky flag on timeout.
module chess_clock_core #(
    parameter int TICK_DIV = 100000000,
    parameter int MIN_W    = 6,
    parameter int INC_EN   = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             set,
    input  logic             enable,
    input  logic [MIN_W-1:0] timeIn,
    input  logic [5:0]       incIn,
    input  logic             player1,
    input  logic             player2,
    output logic [MIN_W-1:0] min1,
    output logic [5:0]       sec1,
    output logic [MIN_W-1:0] min2,
    output logic [5:0]       sec2,
    output logic [1:0]       active,
    output logic             flag1,
    output logic             flag2,
    output logic [1:0]       state_dbg
);

    localparam int               CNT_W   = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);
    localparam logic [MIN_W-1:0] MIN_MAX = '1;

    typedef enum logic [1:0] {IDLE = 2'd0, RUN1 = 2'd1, RUN2 = 2'd2, DONE = 2'd3} state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [5:0]       inc_q, inc_n;
    logic [MIN_W-1:0] min1_n, min2_n;
    logic [5:0]       sec1_n, sec2_n;
    logic             flag1_n, flag2_n;
    logic             press1, press2;

    function automatic logic [MIN_W+5:0] dec_time(input logic [MIN_W-1:0] m, input logic [5:0] s);
        if (s != 6'd0) return {m, s - 6'd1};
        if (m != '0)   return {m - MIN_W'(1), 6'd59};
        return {m, s};
    endfunction

    function automatic logic [MIN_W+5:0] add_inc(input logic [MIN_W-1:0] m, input logic [5:0] s,
                                                 input logic [5:0] i);
        logic [6:0] sum;
        sum = {1'b0, s} + {1'b0, i};
        if (sum >= 7'd60) begin
            if (m == MIN_MAX) return {MIN_MAX, 6'd59};
            return {m + MIN_W'(1), 6'(sum - 7'd60)};
        end
        return {m, sum[5:0]};
    endfunction

    // Simultaneous presses cancel out everywhere.
    assign press1 = player1 & ~player2;
    assign press2 = player2 & ~player1;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        inc_n   = inc_q;
        min1_n  = min1;
        sec1_n  = sec1;
        min2_n  = min2;
        sec2_n  = sec2;
        flag1_n = flag1;
        flag2_n = flag2;
        case (state)
            IDLE: begin
                if (press1) begin
                    cnt_n   = '0;
                    state_n = ({min2, sec2} == '0) ? DONE : RUN2;
                end else if (press2) begin
                    cnt_n   = '0;
                    state_n = ({min1, sec1} == '0) ? DONE : RUN1;
                end
            end
            RUN1: begin
                if (press1) begin
                    cnt_n   = '0;
                    state_n = RUN2;
                    if (INC_EN != 0) {min1_n, sec1_n} = add_inc(min1, sec1, inc_q);
                end else if (enable) begin
                    if (cnt == CNT_MAX) begin
                        cnt_n = '0;
                        {min1_n, sec1_n} = dec_time(min1, sec1);
                        if (min1 == '0 && sec1 == 6'd1) begin
                            flag1_n = 1'b1;
                            state_n = DONE;
                        end
                    end else begin
                        cnt_n = cnt + CNT_W'(1);
                    end
                end
            end
            RUN2: begin
                if (press2) begin
                    cnt_n   = '0;
                    state_n = RUN1;
                    if (INC_EN != 0) {min2_n, sec2_n} = add_inc(min2, sec2, inc_q);
                end else if (enable) begin
                    if (cnt == CNT_MAX) begin
                        cnt_n = '0;
                        {min2_n, sec2_n} = dec_time(min2, sec2);
                        if (min2 == '0 && sec2 == 6'd1) begin
                            flag2_n = 1'b1;
                            state_n = DONE;
                        end
                    end else begin
                        cnt_n = cnt + CNT_W'(1);
                    end
                end
            end
            default: ;
        endcase
        // Increments above 59 are clamped so seconds can never leave 0..59.
        if (set) begin
            state_n = IDLE;
            cnt_n   = '0;
            inc_n   = (incIn > 6'd59) ? 6'd59 : incIn;
            min1_n  = timeIn;
            min2_n  = timeIn;
            sec1_n  = '0;
            sec2_n  = '0;
            flag1_n = 1'b0;
            flag2_n = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            inc_q <= '0;
            min1  <= '0;
            sec1  <= '0;
            min2  <= '0;
            sec2  <= '0;
            flag1 <= 1'b0;
            flag2 <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            inc_q <= inc_n;
            min1  <= min1_n;
            sec1  <= sec1_n;
            min2  <= min2_n;
            sec2  <= sec2_n;
            flag1 <= flag1_n;
            flag2 <= flag2_n;
        end
    end

    assign active    = (state == RUN1) ? 2'b01 : (state == RUN2) ? 2'b10 : 2'b00;
    assign state_dbg = state;

endmodule

// File: tb/tb_chess_clock_core.sv
// Bench for chess_clock_core: a seconds-based reference model feeds an expected queue,
// a negedge monitor compares every cycle; directed scenarios add spot checks.
module tb_chess_clock_core;

    localparam int TICK_DIV = 4;
    localparam int MIN_W    = 6;
    localparam int TMAX     = 63 * 60 + 59;

    logic             clk;
    logic             reset, set, enable, player1, player2;
    logic [MIN_W-1:0] timeIn;
    logic [5:0]       incIn;
    logic [MIN_W-1:0] min1, min2;
    logic [5:0]       sec1, sec2;
    logic [1:0]       active, state_dbg;
    logic             flag1, flag2;

    typedef struct packed {
        logic [1:0] st;
        logic [5:0] m1;
        logic [5:0] s1;
        logic [5:0] m2;
        logic [5:0] s2;
        logic [1:0] act;
        logic       f1;
        logic       f2;
    } obs_t;

    logic [$bits(obs_t)-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    // Model state: times as total seconds; st 0=IDLE 1=RUN1 2=RUN2 3=DONE.
    int m_t1, m_t2, m_st, m_cnt, m_inc, m_f1, m_f2;

    chess_clock_core #(.TICK_DIV(TICK_DIV), .MIN_W(MIN_W), .INC_EN(1)) dut (
        .clk(clk), .reset(reset), .set(set), .enable(enable), .timeIn(timeIn), .incIn(incIn),
        .player1(player1), .player2(player2), .min1(min1), .sec1(sec1), .min2(min2), .sec2(sec2),
        .active(active), .flag1(flag1), .flag2(flag2), .state_dbg(state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic obs_t model_obs();
        obs_t o;
        o.st  = 2'(m_st);
        o.m1  = 6'(m_t1 / 60);
        o.s1  = 6'(m_t1 % 60);
        o.m2  = 6'(m_t2 / 60);
        o.s2  = 6'(m_t2 % 60);
        o.act = (m_st == 1) ? 2'b01 : (m_st == 2) ? 2'b10 : 2'b00;
        o.f1  = m_f1[0];
        o.f2  = m_f2[0];
        return o;
    endfunction

    task automatic model_step(input bit r, s, en, p1, p2, input int ti, inc);
        if (r) begin
            m_t1 = 0; m_t2 = 0; m_st = 0; m_cnt = 0; m_inc = 0; m_f1 = 0; m_f2 = 0;
        end else if (s) begin
            m_t1 = ti * 60; m_t2 = ti * 60; m_st = 0; m_cnt = 0; m_f1 = 0; m_f2 = 0;
            m_inc = (inc > 59) ? 59 : inc;
        end else if (m_st == 0) begin
            if (p1 && !p2) begin m_cnt = 0; m_st = (m_t2 == 0) ? 3 : 2; end
            else if (p2 && !p1) begin m_cnt = 0; m_st = (m_t1 == 0) ? 3 : 1; end
        end else if (m_st == 1) begin
            if (p1 && !p2) begin
                m_cnt = 0; m_st = 2;
                m_t1 = (m_t1 + m_inc > TMAX) ? TMAX : m_t1 + m_inc;
            end else if (en) begin
                if (m_cnt == TICK_DIV - 1) begin
                    m_cnt = 0;
                    if (m_t1 > 0) m_t1 = m_t1 - 1;
                    if (m_t1 == 0) begin m_f1 = 1; m_st = 3; end
                end else m_cnt = m_cnt + 1;
            end
        end else if (m_st == 2) begin
            if (p2 && !p1) begin
                m_cnt = 0; m_st = 1;
                m_t2 = (m_t2 + m_inc > TMAX) ? TMAX : m_t2 + m_inc;
            end else if (en) begin
                if (m_cnt == TICK_DIV - 1) begin
                    m_cnt = 0;
                    if (m_t2 > 0) m_t2 = m_t2 - 1;
                    if (m_t2 == 0) begin m_f2 = 1; m_st = 3; end
                end else m_cnt = m_cnt + 1;
            end
        end
    endtask

    // One clock of stimulus; returns #1 after the following negedge.
    task automatic cycle(input bit r, s, en, p1, p2, input int ti, inc);
        reset = r; set = s; enable = en; player1 = p1; player2 = p2;
        timeIn = MIN_W'(ti); incIn = 6'(inc);
        model_step(r, s, en, p1, p2, ti, inc);
        exp_q.push_back(model_obs());
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic run(input int n, input bit en);
        for (int i = 0; i < n; i++) cycle(0, 0, en, 0, 0, 0, 0);
    endtask

    task automatic expect_eq(input string name, input int act_v, input int exp_v);
        checks++;
        if (act_v != exp_v) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act_v, exp_v);
        end
    endtask

    always @(negedge clk) begin
        obs_t e, a;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = '{st: state_dbg, m1: min1, s1: sec1, m2: min2, s2: sec2, act: active, f1: flag1, f2: flag2};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL outputs @%0t: got st=%0d %0d:%0d %0d:%0d act=%b f=%b%b, expected st=%0d %0d:%0d %0d:%0d act=%b f=%b%b",
                         $time, a.st, a.m1, a.s1, a.m2, a.s2, a.act, a.f1, a.f2,
                         e.st, e.m1, e.s1, e.m2, e.s2, e.act, e.f1, e.f2);
            end
        end
    end

    initial begin
        int wait_cnt;
        reset = 1; set = 0; enable = 0; player1 = 0; player2 = 0; timeIn = 0; incIn = 0;
        cycle(1, 0, 0, 0, 0, 0, 0);
        cycle(1, 0, 1, 1, 0, 5, 5);
        expect_eq("reset_min1", int'(min1), 0);
        expect_eq("reset_active", int'(active), 0);

        // 1:00 each, no increment; P2 starts P1's clock.
        cycle(0, 1, 1, 0, 0, 1, 0);
        cycle(0, 0, 1, 0, 1, 0, 0);
        expect_eq("start_active", int'(active), 1);
        run(4, 1);
        expect_eq("first_tick_min1", int'(min1), 0);
        expect_eq("first_tick_sec1", int'(sec1), 59);

        // Increment 5: P1 at 0:58 presses -> 1:03, counter restarts.
        cycle(0, 1, 1, 0, 0, 1, 5);
        cycle(0, 0, 1, 0, 1, 0, 0);
        run(8, 1);
        expect_eq("pre_inc_sec1", int'(sec1), 58);
        cycle(0, 0, 1, 1, 0, 0, 0);
        expect_eq("inc_min1", int'(min1), 1);
        expect_eq("inc_sec1", int'(sec1), 3);
        expect_eq("inc_active", int'(active), 2);
        run(3, 1);
        expect_eq("inc_no_early_tick", int'(sec2), 0);
        run(1, 1);
        expect_eq("inc_tick_sec2", int'(sec2), 59);

        // P2 runs down to 0:01, then flags on the next tick.
        cycle(0, 1, 1, 0, 0, 1, 0);
        cycle(0, 0, 1, 1, 0, 0, 0);
        run(59 * 4, 1);
        expect_eq("p2_at_one_sec", int'(sec2), 1);
        run(4, 1);
        expect_eq("flag2", int'(flag2), 1);
        expect_eq("flag_sec2", int'(sec2), 0);
        expect_eq("flag_active", int'(active), 0);
        cycle(0, 0, 1, 0, 1, 0, 0);
        cycle(0, 0, 0, 1, 0, 0, 0);
        run(8, 1);
        expect_eq("done_hold_sec1", int'(sec1), 0);
        expect_eq("done_hold_min1", int'(min1), 1);

        // Pause mid-second, then resume: only the remaining cycles elapse.
        cycle(0, 1, 1, 0, 0, 2, 0);
        cycle(0, 0, 1, 0, 1, 0, 0);
        run(2, 1);
        run(10, 0);
        expect_eq("pause_sec1", int'(sec1), 0);
        run(1, 1);
        expect_eq("resume_min1_hold", int'(min1), 2);
        run(1, 1);
        expect_eq("resume_tick_sec1", int'(sec1), 59);

        // Simultaneous presses ignored; reset mid-run clears everything.
        cycle(0, 0, 1, 1, 1, 0, 0);
        expect_eq("both_pressed_active", int'(active), 1);
        cycle(0, 0, 1, 1, 0, 0, 0);
        expect_eq("run2_active", int'(active), 2);
        cycle(1, 1, 1, 0, 1, 7, 7);
        expect_eq("midrun_reset_min1", int'(min1), 0);
        expect_eq("midrun_reset_active", int'(active), 0);

        // timeIn = 0: first press goes straight to DONE without a flag.
        cycle(0, 1, 1, 0, 0, 0, 3);
        cycle(0, 0, 1, 1, 0, 0, 0);
        expect_eq("zero_load_state", int'(state_dbg), 3);
        expect_eq("zero_load_flag", int'(flag1) + int'(flag2), 0);

        // Saturation: climb P1 to 63:58 with inc 10, next press caps at 63:59.
        cycle(0, 1, 1, 0, 0, 63, 10);
        cycle(0, 0, 1, 0, 1, 0, 0);
        run(8, 1);
        cycle(0, 0, 1, 1, 0, 0, 0);
        for (int k = 0; k < 5; k++) begin
            cycle(0, 0, 1, 0, 1, 0, 0);
            cycle(0, 0, 1, 1, 0, 0, 0);
        end
        expect_eq("pre_sat_sec1", int'(sec1), 58);
        cycle(0, 0, 1, 0, 1, 0, 0);
        cycle(0, 0, 1, 1, 0, 0, 0);
        expect_eq("sat_min1", int'(min1), 63);
        expect_eq("sat_sec1", int'(sec1), 59);

        // Random play with short games so flags and DONE are reached often.
        for (int i = 0; i < 4000; i++) begin
            bit r, s, en, p1, p2;
            int ti, inc;
            r   = ($urandom_range(0, 599) == 0);
            s   = ($urandom_range(0, 149) == 0);
            en  = ($urandom_range(0, 9) < 8);
            p1  = ($urandom_range(0, 19) == 0);
            p2  = ($urandom_range(0, 19) == 0);
            ti  = ($urandom_range(0, 4) == 0) ? $urandom_range(60, 63) : $urandom_range(0, 2);
            inc = $urandom_range(0, 63);
            cycle(r, s, en, p1, p2, ti, inc);
        end

        wait_cnt = 0;
        while (exp_q.size() > 0 && wait_cnt < 10) begin
            @(negedge clk);
            #1;
            wait_cnt++;
        end
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/chess_clock_core.md
CHESS_CLOCK_CORE -- requirements
Module: chess_clock_core

Interface
REQ-001 SHALL provide parameters, one per line as name, default, meaning:
- TICK_DIV, 100000000, clk cycles per one-second tick (>=2)
- MIN_W, 6, width of minute fields
- INC_EN, 1, 1 = Fischer increment mode, 0 = sudden death
REQ-002 SHALL provide ports, one per line as name, direction, width, meaning:
- clk, in, 1, sole clock, all state on rising edge
- reset, in, 1, synchronous active-high reset
- set, in, 1, load pulse: loads both clocks from timeIn/incIn
- enable, in, 1, 0 = pause, 1 = run
- timeIn, in, MIN_W, initial minutes per player
- incIn, in, 6, increment seconds (0..59)
- player1, in, 1, one-cycle pulse, player 1 ends turn
- player2, in, 1, one-cycle pulse, player 2 ends turn
- min1 / sec1, out, MIN_W / 6, player 1 remaining time
- min2 / sec2, out, MIN_W / 6, player 2 remaining time
- active, out, 2, one-hot running player (01 = P1, 10 = P2, 00 = none)
- flag1 / flag2, out, 1, player has run out of time (sticky)
REQ-003 SHALL use one clock, clk; reset is synchronous and active-high; no other asynchronous inputs.

Function
REQ-004 SHALL implement FSM states IDLE, RUN1, RUN2, DONE; active = 00 in IDLE/DONE, 01 in RUN1, 10 in RUN2.
REQ-005 SHALL, on set (any state), load min1 = min2 = timeIn, sec1 = sec2 = 0, latch incIn, clear flags and tick counter, and enter IDLE; set has priority over every input except reset.
REQ-006 SHALL, in IDLE, on player1 pulse enter RUN2, and on player2 pulse enter RUN1 (the pressing player hands the move to the opponent); no increment is applied on the starting press.
REQ-007 SHALL, in RUN1, on player1 pulse enter RUN2; in RUN2, on player2 pulse enter RUN1; a press by the non-running player is ignored.
REQ-008 SHALL ignore simultaneous player1 and player2 pulses in the same cycle in all states.
REQ-009 SHALL count the tick counter 0..TICK_DIV-1 only in RUN1/RUN2 while enable = 1, asserting an internal tick on the cycle the counter equals TICK_DIV-1, then wrapping to 0.
REQ-010 SHALL hold the tick counter (no reset) while enable = 0; player presses are still accepted while paused.
REQ-011 SHALL clear the tick counter to 0 on every accepted turn change.
REQ-012 SHALL, on tick, decrement the running player's time: sec > 0 -> sec-1; sec = 0 and min > 0 -> sec = 59, min-1.
REQ-013 SHALL, on a tick where running player's time is 0:01, update the time to 0:00, set that player's flag, and enter DONE in the same cycle.
REQ-014 SHALL, if a load gives timeIn = 0, enter DONE with no flag upon the first press from IDLE.
REQ-015 SHALL, when INC_EN = 1, on an accepted turn-ending press add latched inc to the pressing player's time: sec+inc >= 60 -> sec = sec+inc-60, min+1; min saturates at 2^MIN_W-1 with sec = 59.
REQ-016 SHALL, when a press and a tick coincide, process the press only; that tick is discarded.
REQ-017 SHALL, in DONE, hold all times and flags and ignore player1, player2, and enable until set or reset.
REQ-018 SHALL keep sec1/sec2 always in 0..59.

Reset
REQ-019 SHALL, on reset, set min1 = min2 = 0, sec1 = sec2 = 0, active = 00, flag1 = flag2 = 0, tick counter = 0, latched inc = 0, state = IDLE.
REQ-020 SHALL give reset priority over set and all other inputs; reset mid-run returns to IDLE next cycle with all outputs at reset values.

Verification (TICK_DIV = 4, MIN_W = 6)
REQ-021 SHALL cover: set with timeIn = 1, incIn = 0, pulse player2 -> active = 01; after 4 enabled cycles min1 = 0, sec1 = 59.
REQ-022 SHALL cover: INC_EN = 1, incIn = 5, P1 at 0:58 presses -> min1 = 1, sec1 = 3, active = 10, tick counter = 0.
REQ-023 SHALL cover: P2 running at 0:01, one tick -> sec2 = 0, flag2 = 1, active = 00; later player presses cause no change.
REQ-024 SHALL cover: enable = 0 for 10 cycles mid-second -> times unchanged and tick counter held; resume -> next tick occurs after the remaining cycles only.
REQ-025 SHALL cover: simultaneous player1 and player2 pulses in RUN1 -> no state change; then reset during RUN2 -> all outputs zero next cycle.
REQ-026 SHALL cover: min1 = 63, sec1 = 58, incIn = 10, P1 press -> min1 = 63, sec1 = 59 (saturation).
